// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two line buffers.
// Optional start-of-frame input is enabled by defining LINE_WINDOW_SOF_EN.
module line_window_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
`ifdef LINE_WINDOW_SOF_EN
  input  logic       sof,
`endif
  output logic [7:0] window [9],
  output logic       win_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d, eff_col_s;
  logic [RW-1:0] row_q, row_d, eff_row_s;
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb2_q [IMG_W];
  logic [7:0]    sr_q  [6];
  logic [7:0]    lb1_rd_s, lb2_rd_s;
  logic          sof_s, fire_s;

`ifdef LINE_WINDOW_SOF_EN
  assign sof_s = pix_valid & sof;
`else
  assign sof_s = 1'b0;
`endif

  // An accepted sof pixel is placed at (0,0) regardless of the running counters
  always_comb begin
    eff_col_s = col_q;
    eff_row_s = row_q;
    if (sof_s) begin
      eff_col_s = '0;
      eff_row_s = '0;
    end else begin
      eff_col_s = col_q;
      eff_row_s = row_q;
    end
  end

  assign lb1_rd_s = lb1_q[eff_col_s];
  assign lb2_rd_s = lb2_q[eff_col_s];
  assign fire_s   = pix_valid && (eff_row_s >= RW'(2)) && (eff_col_s >= CW'(2));

  // Raster position of the next accepted pixel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (eff_col_s == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (eff_row_s == RW'(IMG_H - 1)) begin
          row_d = '0;
        end else begin
          row_d = eff_row_s + RW'(1);
        end
      end else begin
        col_d = eff_col_s + CW'(1);
        row_d = eff_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2; lb1's old entry ages into lb2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= 8'd0;
        lb2_q[i] <= 8'd0;
      end
    end else if (pix_valid) begin
      lb1_q[eff_col_s] <= pix_in;
      lb2_q[eff_col_s] <= lb1_rd_s;
    end
  end

  // Two previous columns per window row; at c=2 they hold columns 0 and 1 of this band
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        sr_q[i] <= 8'd0;
      end
    end else if (pix_valid) begin
      sr_q[0] <= sr_q[1];
      sr_q[1] <= lb2_rd_s;
      sr_q[2] <= sr_q[3];
      sr_q[3] <= lb1_rd_s;
      sr_q[4] <= sr_q[5];
      sr_q[5] <= pix_in;
    end
  end

  // Window output register: loads only when a complete window exists, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        window[i] <= 8'd0;
      end
      win_valid <= 1'b0;
    end else begin
      win_valid <= fire_s;
      if (fire_s) begin
        window[0] <= sr_q[0];
        window[1] <= sr_q[1];
        window[2] <= lb2_rd_s;
        window[3] <= sr_q[2];
        window[4] <= sr_q[3];
        window[5] <= lb1_rd_s;
        window[6] <= sr_q[4];
        window[7] <= sr_q[5];
        window[8] <= pix_in;
      end
    end
  end

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed self-checking bench for line_window_3x3 with a 4x4 image, pixel value 4*r+c.
module tb_line_window_3x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] window [9];
  logic       win_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0] obs_win [64][9];
  logic       obs_wv  [64];
  int         n_obs;
  int         gap_hits;

  always #5 clk = ~clk;

  line_window_3x3 #(.IMG_W(4), .IMG_H(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
`ifdef LINE_WINDOW_SOF_EN
    .sof       (sof),
`endif
    .window    (window),
    .win_valid (win_valid)
  );

  // Expected tap k for the frame pixel with index i (row-major, value = 4*r+c)
  function automatic logic [7:0] exp_tap(input int i, input int k);
    int r, c;
    r = (i % 16) / 4;
    c = i % 4;
    return 8'(4 * (r - 2 + k / 3) + (c - 2 + k % 3));
  endfunction

  task automatic send(input logic [7:0] v, input logic s);
    @(negedge clk);
    pix_in    = v;
    pix_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    obs_wv[n_obs] = win_valid;
    for (int k = 0; k < 9; k++) obs_win[n_obs][k] = window[k];
    n_obs++;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n, input logic s);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      sof = s;
      @(posedge clk);
      #1;
      if (win_valid) gap_hits++;
    end
    sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; pix_in = 8'd0; sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_wv got=%b exp=0", win_valid); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (window[k] !== 8'd0) begin failures++; $display("FAIL reset_win[%0d] got=%0d exp=0", k, window[k]); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (win_valid !== 1'b0) begin failures++; $display("FAIL post_reset_wv got=%b exp=0", win_valid); end
  endtask

  task automatic test_contiguous();
    int strobes;
    n_obs = 0; strobes = 0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = (i == 10) || (i == 11) || (i == 14) || (i == 15);
      checks++;
      if (obs_wv[i] !== ev) begin failures++; $display("FAIL contig_wv px=%0d got=%b exp=%b", i, obs_wv[i], ev); end
      if (obs_wv[i]) strobes++;
      if (ev) begin
        for (int k = 0; k < 9; k++) begin
          checks++;
          if (obs_win[i][k] !== exp_tap(i, k)) begin
            failures++; $display("FAIL contig_win px=%0d k=%0d got=%0d exp=%0d", i, k, obs_win[i][k], exp_tap(i, k));
          end
        end
      end
    end
    checks++;
    if (strobes !== 4) begin failures++; $display("FAIL contig_strobes got=%0d exp=4", strobes); end
    checks++;
    if (obs_win[10][0] !== 8'd0 || obs_win[10][4] !== 8'd5 || obs_win[10][8] !== 8'd10) begin
      failures++; $display("FAIL contig_first got=%0d,%0d,%0d exp=0,5,10", obs_win[10][0], obs_win[10][4], obs_win[10][8]);
    end
    checks++;
    if (obs_win[15][0] !== 8'd5 || obs_win[15][4] !== 8'd10 || obs_win[15][8] !== 8'd15) begin
      failures++; $display("FAIL contig_last got=%0d,%0d,%0d exp=5,10,15", obs_win[15][0], obs_win[15][4], obs_win[15][8]);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs_win[12][k] !== obs_win[11][k]) begin
        failures++; $display("FAIL contig_hold k=%0d got=%0d exp=%0d", k, obs_win[12][k], obs_win[11][k]);
      end
    end
  endtask

  task automatic test_median();
    logic [7:0] a [9];
    logic [7:0] t;
    for (int k = 0; k < 9; k++) a[k] = obs_win[10][k];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j + 1]) begin t = a[j]; a[j] = a[j + 1]; a[j + 1] = t; end
    checks++;
    if (a[4] !== 8'd5) begin failures++; $display("FAIL median got=%0d exp=5", a[4]); end
  endtask

  task automatic test_gaps();
    n_obs = 0; gap_hits = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      idle(3, 1'b0);
    end
    checks++;
    if (gap_hits !== 0) begin failures++; $display("FAIL gaps_wv_in_gap got=%0d exp=0", gap_hits); end
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = ((i % 4) >= 2) && ((i / 4) >= 2);
      checks++;
      if (obs_wv[i] !== ev) begin failures++; $display("FAIL gaps_wv px=%0d got=%b exp=%b", i, obs_wv[i], ev); end
      if (ev) begin
        for (int k = 0; k < 9; k++) begin
          checks++;
          if (obs_win[i][k] !== exp_tap(i, k)) begin
            failures++; $display("FAIL gaps_win px=%0d k=%0d got=%0d exp=%0d", i, k, obs_win[i][k], exp_tap(i, k));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int strobes;
    n_obs = 0; strobes = 0;
    for (int i = 0; i < 32; i++) send(8'(i % 16), 1'b0);
    for (int i = 0; i < 32; i++) if (obs_wv[i]) strobes++;
    checks++;
    if (strobes !== 8) begin failures++; $display("FAIL b2b_strobes got=%0d exp=8", strobes); end
    checks++;
    if (obs_wv[26] !== 1'b1) begin failures++; $display("FAIL b2b_f2_first_wv got=%b exp=1", obs_wv[26]); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs_win[26][k] !== exp_tap(10, k)) begin
        failures++; $display("FAIL b2b_f2_first k=%0d got=%0d exp=%0d", k, obs_win[26][k], exp_tap(10, k));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int strobes;
    n_obs = 0; strobes = 0;
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (win_valid !== 1'b0) begin failures++; $display("FAIL midrst_wv got=%b exp=0", win_valid); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (window[k] !== 8'd0) begin failures++; $display("FAIL midrst_win[%0d] got=%0d exp=0", k, window[k]); end
    end
    @(negedge clk) rst_n = 1'b1;
    n_obs = 0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = ((i % 4) >= 2) && ((i / 4) >= 2);
      if (obs_wv[i]) strobes++;
      checks++;
      if (obs_wv[i] !== ev) begin failures++; $display("FAIL midrst_restream_wv px=%0d got=%b exp=%b", i, obs_wv[i], ev); end
    end
    checks++;
    if (strobes !== 4) begin failures++; $display("FAIL midrst_strobes got=%0d exp=4", strobes); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs_win[10][k] !== exp_tap(10, k)) begin
        failures++; $display("FAIL midrst_first k=%0d got=%0d exp=%0d", k, obs_win[10][k], exp_tap(10, k));
      end
    end
  endtask

`ifdef LINE_WINDOW_SOF_EN
  task automatic test_sof();
    int strobes;
    n_obs = 0; strobes = 0;
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
    idle(1, 1'b1);
    for (int i = 10; i < 16; i++) send(8'(i), 1'b0);
    checks++;
    if (obs_wv[10] !== 1'b1) begin failures++; $display("FAIL sof_idle_ignored got=%b exp=1", obs_wv[10]); end
    n_obs = 0;
    for (int i = 0; i < 6; i++) send(8'(i), 1'b0);
    for (int i = 0; i < 16; i++) send(8'(i), (i == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 22; i++) if (obs_wv[i]) strobes++;
    checks++;
    if (strobes !== 4) begin failures++; $display("FAIL sof_strobes got=%0d exp=4", strobes); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs_win[16][k] !== exp_tap(10, k)) begin
        failures++; $display("FAIL sof_first k=%0d got=%0d exp=%0d", k, obs_win[16][k], exp_tap(10, k));
      end
    end
  endtask
`endif

  initial begin
    n_obs = 0;
    gap_hits = 0;
    test_reset();
    test_contiguous();
    test_median();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
`ifdef LINE_WINDOW_SOF_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
